// File: rtl/timer_scheduler.sv
// timer_scheduler: one shared interval timer, round-robin granted to NREQ
// requesters; each run lasts (tvalue << mult) - 1 cycles, then a done pulse.
//   clk, reset (async, active-low)
//   req[NREQ], mult[2*NREQ] : request strobes and per-requester 2-bit scale
//   gnt, done, pending      : one-hot grant, one-cycle done, queued requests
//   busy, cf                : timer running / timer free (~busy)
module timer_scheduler #(
  parameter int NREQ   = 4,
  parameter int tvalue = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] mult,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   pending,
  output logic              busy,
  output logic              cf
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [18:0] TV = 19'(tvalue);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [NREQ-1:0] pend_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [1:0]      mreg_q [NREQ];
  logic [18:0]     rem_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_q;

  logic [1:0]      mult_a [NREQ];
  logic [NREQ-1:0] cap;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] pend_d;
  logic [IW-1:0]   idx_v;
  logic [IW-1:0]   sel;
  logic            found;
  logic            arb;
  logic [1:0]      m_sel;
  logic [18:0]     run_len;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      mult_a[i] = mult[2*i +: 2];
    end
  end

  // A requester already queued or running is deaf to req.
  assign cap  = req & ~pend_q & ~gnt_q;
  assign cand = pend_q | cap;

  // Scan last+1, last+2, ... and keep the first candidate.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx_v = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_v = IW'((int'(last_q) + off) % NREQ);
      if (!found && cand[idx_v]) begin
        found = 1'b1;
        sel   = idx_v;
      end
    end
  end

  assign arb    = (state_q == IDLE) && found;
  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign pend_d = cand & ~(arb ? win_oh : '0);

  // A same-edge capture has not reached mreg yet.
  assign m_sel   = cap[sel] ? mult_a[sel] : mreg_q[sel];
  assign run_len = (TV << m_sel) - 19'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      win_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        mreg_q[i] <= '0;
      end
    end else begin
      done_q <= '0;
      pend_q <= pend_d;
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          mreg_q[i] <= mult_a[i];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            last_q  <= sel;
            win_q   <= sel;
            rem_q   <= run_len;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_q - 19'd1;
          if (rem_q == 19'd1) begin
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q[win_q] <= 1'b1;
            state_q       <= IDLE;
          end
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign pending = pend_q;
  assign busy    = busy_q;
  assign cf      = ~busy_q;

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one parametrized interval timer among NREQ requesters. Each requester posts a timing request with its own 2-bit multiplier. A round-robin arbiter grants the timer to one requester at a time. The granted run lasts M×tvalue−1 cycles and ends with a one-cycle per-requester done pulse. The block sits between client FSMs that need delays and the shared timing resource, and replaces one counter per client.

## Interface
- NREQ, 4: number of requesters, 2..8.
- tvalue, 4: base interval n, 2..65535; must be ≥2 so that every run length is ≥1.
- clk  input  1  clock, positive edge.
- reset  input  1  asynchronous, active-low (1'b0 = reset).
- req  input  NREQ  per-requester request strobe, active 1'b1; sampled every edge.
- mult  input  2×NREQ  per-requester multiplier, bits [2i+1:2i] for requester i; 00=1×, 01=2×, 10=4×, 11=8×.
- gnt  output  NREQ  one-hot grant, high for the whole run of the winner.
- done  output  NREQ  one-hot, one-cycle pulse after the winner's run ends.
- pending  output  NREQ  queued but not yet granted requests.
- busy  output  1  high while any gnt bit is high.
- cf  output  1  ~busy; low while the timer runs.

## Operation
- Internal state:
  - FSM with two states, IDLE and RUN.
  - pending[NREQ].
  - Latched multiplier mreg[i] per requester.
  - remaining count, 19 bits; the maximum run is 8×65535−1.
  - Round-robin pointer last (index of the last winner).
  - Winner index win.
- Request capture, per requester, at every edge:
  - Captured when req[i]=1, pending[i]=0 and gnt[i]=0: pending[i]<=1 and mreg[i]<=mult[i].
  - A request from a requester that is already pending or granted is ignored, and its multiplier is not re-sampled.
- Arbitration happens only in IDLE:
  - Candidates are pending | captured-this-edge. A request seen at an edge while IDLE can therefore win at that same edge.
  - Priority order is last+1, last+2, … modulo NREQ.
  - The winner's pending bit is cleared, and gnt[win], busy and last<=win are set.
  - Run length L = (tvalue << mreg[win]) − 1 (shift by 0..3). The count is loaded: remaining<=L. The FSM goes to RUN.
- RUN:
  - remaining decrements by 1 every edge.
  - At the edge where remaining==1: gnt<=0, done[win]<=1, FSM to IDLE.
  - New requests keep queueing in pending during RUN.
- IDLE after a run: done is high for exactly that one cycle. The next arbitration happens at the following edge.
- Reset, asserted at any time (including mid-run) and taking effect immediately:
  - pending, gnt, done, busy and remaining are cleared to 0, and cf goes to 1.
  - last is set to NREQ−1, so requester 0 has top priority after reset.
  - FSM goes to IDLE and mreg is set to 0.
  - No done pulse is produced for an aborted run.

## Timing
- Grant latency: req[i] high at edge k with the block IDLE and no higher-priority candidate → gnt[i] high from edge k.
- gnt[win] stays high for exactly L cycles. cf is low for exactly L cycles, e.g. tvalue=7 with 2× gives 13 cycles.
- done[win] is high for the 1 cycle immediately after gnt falls.
- Minimum gap between consecutive grants is 1 cycle: the done cycle, during which gnt=0 and busy=0.
- Requester i that re-asserts req during its own done cycle is captured at the next edge. It competes under the updated pointer, so other pending requesters are served first.
- Changing mult[i] after capture has no effect until the next capture.
- All outputs are registered except cf (=~busy) and pending, which is a direct register view.

## Test plan
- tvalue=7, NREQ=4: reset released; req[0] pulsed 1 cycle with mult[1:0]=01 → gnt[0] high 13 cycles, cf low 13 cycles, then done[0] high 1 cycle, busy low.
- req[0] and req[2] in the same cycle, both 00 → gnt[0] for 6 cycles, done[0], one idle cycle, gnt[2] for 6 cycles, done[2]; pending[2] high while waiting.
- req all four held continuously, mult=00 → grant order 0,1,2,3,0,1… with exactly one done cycle between grants.
- mult[1:0]=00 at capture, changed to 11 during the run, and req[0] re-pulsed during gnt[0] → run stays 6 cycles, no extra grant to 0.
- Run with 8× (55 cycles), reset driven low at cycle 20 asynchronously (mid-cycle) → gnt/busy/done/pending go to 0 at once, cf=1, no done pulse. After release, req[3] alone → gnt[3] granted normally.
- tvalue=2, mult 00 → gnt high exactly 1 cycle, done next cycle (minimum-length boundary).
